clock_set_ctrl: RTL and testbench

//  Mode/time-setting controller for the digital clock datapath. Sits between the
//  1 Hz tick, two debounced buttons and the sec (mod-60), min (mod-60) and hour
//  (mod-24) BCD counters. Generates their count enables, synchronous loads and

---
 rtl/clock_set_ctrl.sv | 134 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/time-setting controller for the digital clock: drives the sec/min/hour
// BCD counter enables, loads and clears, and the display blink flags.
module clock_set_ctrl #(
    parameter int TIMEOUT_S = 10,
    parameter int TW        = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_co,
    input  logic       min_co,
    input  logic [1:0] h1,
    input  logic [3:0] h0,
    input  logic [2:0] m1,
    input  logic [3:0] m0,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       sec_clr,
    output logic       hour_load,
    output logic [1:0] hour_d1,
    output logic [3:0] hour_d0,
    output logic       min_load,
    output logic [2:0] min_d1,
    output logic [3:0] min_d0,
    output logic [1:0] mode,
    output logic       blink_hr,
    output logic       blink_min
);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);

    state_t        state, state_n;
    logic          btn_mode_q, btn_inc_q;
    logic          mode_p, inc_p, to_hit, enter_set;
    logic [TW-1:0] tcnt;
    logic          phase;
    logic [1:0]    nh1;
    logic [3:0]    nh0;
    logic [2:0]    nm1;
    logic [3:0]    nm0;

    // Mode press shadows a simultaneous inc press; an inc press restarts the
    // timeout, so it also suppresses a timeout on the same tick.
    assign mode_p = btn_mode & ~btn_mode_q;
    assign inc_p  = btn_inc & ~btn_inc_q & ~mode_p;
    assign to_hit = (TIMEOUT_S != 0) && tick && !inc_p && (tcnt == TLAST);

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (mode_p) state_n = SET_HR;
            SET_HR:  if (mode_p) state_n = SET_MIN;
                     else if (to_hit) state_n = RUN;
            SET_MIN: if (mode_p || to_hit) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    assign enter_set = (state_n != state) && (state_n != RUN);

    always_comb begin
        nh1 = h1;
        nh0 = h0 + 4'd1;
        if (h1 == 2'd2 && h0 == 4'd3) begin
            nh1 = 2'd0;
            nh0 = 4'd0;
        end else if (h0 == 4'd9) begin
            nh1 = h1 + 2'd1;
            nh0 = 4'd0;
        end
        nm1 = m1;
        nm0 = m0 + 4'd1;
        if (m1 == 3'd5 && m0 == 4'd9) begin
            nm1 = 3'd0;
            nm0 = 4'd0;
        end else if (m0 == 4'd9) begin
            nm1 = m1 + 3'd1;
            nm0 = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= RUN;
            btn_mode_q <= 1'b1;
            btn_inc_q  <= 1'b1;
            tcnt       <= '0;
            phase      <= 1'b0;
            sec_clr    <= 1'b0;
            hour_load  <= 1'b0;
            min_load   <= 1'b0;
            hour_d1    <= '0;
            hour_d0    <= '0;
            min_d1     <= '0;
            min_d0     <= '0;
        end else begin
            state      <= state_n;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            sec_clr    <= (state == SET_MIN) && (state_n != SET_MIN);
            hour_load  <= (state == SET_HR) && inc_p;
            min_load   <= (state == SET_MIN) && inc_p;
            if ((state == SET_HR) && inc_p) begin
                hour_d1 <= nh1;
                hour_d0 <= nh0;
            end
            if ((state == SET_MIN) && inc_p) begin
                min_d1 <= nm1;
                min_d0 <= nm0;
            end
            if (state_n == RUN || enter_set || inc_p)
                tcnt <= '0;
            else if (tick && TIMEOUT_S != 0)
                tcnt <= tcnt + TW'(1);
            if (enter_set || inc_p)
                phase <= 1'b0;
            else if (tick)
                phase <= ~phase;
        end
    end

    assign sec_en    = (state == RUN) && tick;
    assign min_en    = (state == RUN) && tick && sec_co;
    assign hour_en   = (state == RUN) && tick && sec_co && min_co;
    assign mode      = state;
    assign blink_hr  = phase && (state == SET_HR);
    assign blink_min = phase && (state == SET_MIN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed vector bench for clock_set_ctrl: one table of per-cycle records plus
// timeout sequences in SET_HR and SET_MIN.
module tb_clock_set_ctrl;

    typedef struct packed {
        logic       clr, tick, bm, bi, sco, mco;
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } in_t;

    typedef struct packed {
        logic [1:0] mode;
        logic       se, me, he, sc, hl, ml, bh, bmn;
        logic [1:0] hd1;
        logic [3:0] hd0;
        logic [2:0] md1;
        logic [3:0] md0;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr, tick, btn_mode, btn_inc, sec_co, min_co;
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
    logic       sec_en, min_en, hour_en, sec_clr, hour_load, min_load;
    logic [1:0] hour_d1;
    logic [3:0] hour_d0;
    logic [2:0] min_d1;
    logic [3:0] min_d0;
    logic [1:0] mode;
    logic       blink_hr, blink_min;
    out_t       act;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    clock_set_ctrl #(.TIMEOUT_S(10), .TW(4)) dut (
        .clk(clk), .clr(clr), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_co(sec_co), .min_co(min_co), .h1(h1), .h0(h0), .m1(m1), .m0(m0),
        .sec_en(sec_en), .min_en(min_en), .hour_en(hour_en), .sec_clr(sec_clr),
        .hour_load(hour_load), .hour_d1(hour_d1), .hour_d0(hour_d0),
        .min_load(min_load), .min_d1(min_d1), .min_d0(min_d0), .mode(mode),
        .blink_hr(blink_hr), .blink_min(blink_min)
    );

    assign act = {mode, sec_en, min_en, hour_en, sec_clr, hour_load, min_load,
                  blink_hr, blink_min, hour_d1, hour_d0, min_d1, min_d0};

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input in_t i);
        clr = i.clr; tick = i.tick; btn_mode = i.bm; btn_inc = i.bi;
        sec_co = i.sco; min_co = i.mco; h1 = i.h1; h0 = i.h0; m1 = i.m1; m0 = i.m0;
    endtask

    // One cycle of tick/mode/inc, released just after the sampling edge.
    task automatic cyc(input logic t, input logic m, input logic i);
        tick = t; btn_mode = m; btn_inc = i;
        @(posedge clk); #1;
        tick = 0; btn_mode = 0; btn_inc = 0;
    endtask

    initial begin
        //   in: clr tick bm bi sco mco h1 h0 m1 m0
        //  out: mode se me he sc hl ml bh bmn hd1 hd0 md1 md0
        add('{1,0,0,0,0,0,1,2,3,4}, '{0,0,0,0,0,0,0,0,0,0,0,0,0}); // 0 reset
        add('{0,1,0,0,1,1,2,3,5,9}, '{0,1,1,1,0,0,0,0,0,0,0,0,0}); // 1 23:59:59 tick
        add('{0,1,0,0,1,0,2,3,5,9}, '{0,1,1,0,0,0,0,0,0,0,0,0,0}); // 2
        add('{0,0,1,0,0,0,2,3,5,9}, '{0,0,0,0,0,0,0,0,0,0,0,0,0}); // 3 mode press
        add('{0,0,0,1,0,0,2,3,5,9}, '{1,0,0,0,0,0,0,0,0,0,0,0,0}); // 4 inc @23
        add('{0,0,0,0,0,0,0,9,5,9}, '{1,0,0,0,0,1,0,0,0,0,0,0,0}); // 5 load 00
        add('{0,0,0,1,0,0,0,9,5,9}, '{1,0,0,0,0,0,0,0,0,0,0,0,0}); // 6 inc @09
        add('{0,0,0,0,0,0,0,9,5,9}, '{1,0,0,0,0,1,0,0,0,1,0,0,0}); // 7 load 10
        add('{0,1,0,0,1,1,0,9,5,9}, '{1,0,0,0,0,0,0,0,0,1,0,0,0}); // 8 tick, no en
        add('{0,0,0,0,0,0,0,9,5,9}, '{1,0,0,0,0,0,0,1,0,1,0,0,0}); // 9 blank
        add('{0,0,0,1,0,0,1,2,5,9}, '{1,0,0,0,0,0,0,1,0,1,0,0,0}); // 10 inc @12
        add('{0,0,1,0,0,0,1,2,5,9}, '{1,0,0,0,0,1,0,0,0,1,3,0,0}); // 11 load 13, mode
        add('{0,0,0,1,0,0,1,2,5,9}, '{2,0,0,0,0,0,0,0,0,1,3,0,0}); // 12 inc @59
        add('{0,0,0,0,0,0,1,2,5,9}, '{2,0,0,0,0,0,1,0,0,1,3,0,0}); // 13 load 00
        add('{0,0,0,1,0,0,1,2,3,9}, '{2,0,0,0,0,0,0,0,0,1,3,0,0}); // 14 inc @39
        add('{0,0,1,0,0,0,1,2,3,9}, '{2,0,0,0,0,0,1,0,0,1,3,4,0}); // 15 load 40, mode
        add('{0,0,0,0,0,0,1,2,3,9}, '{0,0,0,0,1,0,0,0,0,1,3,4,0}); // 16 sec_clr
        add('{0,0,0,1,0,0,1,2,3,9}, '{0,0,0,0,0,0,0,0,0,1,3,4,0}); // 17 inc in RUN
        add('{0,0,0,0,0,0,1,2,3,9}, '{0,0,0,0,0,0,0,0,0,1,3,4,0}); // 18 no load
        add('{0,0,1,0,0,0,1,2,3,9}, '{0,0,0,0,0,0,0,0,0,1,3,4,0}); // 19 mode
        add('{0,0,0,0,0,0,1,2,3,9}, '{1,0,0,0,0,0,0,0,0,1,3,4,0}); // 20
        add('{0,0,1,1,0,0,0,5,3,9}, '{1,0,0,0,0,0,0,0,0,1,3,4,0}); // 21 mode+inc
        add('{0,0,0,0,0,0,0,5,3,9}, '{2,0,0,0,0,0,0,0,0,1,3,4,0}); // 22 no hour_load
        add('{1,0,0,1,0,0,0,5,3,9}, '{2,0,0,0,0,0,0,0,0,1,3,4,0}); // 23 clr in SET_MIN
        add('{0,0,0,1,0,0,0,5,3,9}, '{0,0,0,0,0,0,0,0,0,0,0,0,0}); // 24 inc held
        add('{0,0,1,1,0,0,0,5,3,9}, '{0,0,0,0,0,0,0,0,0,0,0,0,0}); // 25 mode
        add('{0,0,0,1,0,0,2,3,3,9}, '{1,0,0,0,0,0,0,0,0,0,0,0,0}); // 26 held
        add('{0,0,0,1,0,0,2,3,3,9}, '{1,0,0,0,0,0,0,0,0,0,0,0,0}); // 27 held
        add('{0,0,0,0,0,0,2,3,3,9}, '{1,0,0,0,0,0,0,0,0,0,0,0,0}); // 28 release
        add('{0,0,0,1,0,0,1,4,3,9}, '{1,0,0,0,0,0,0,0,0,0,0,0,0}); // 29 re-press @14
        add('{0,0,0,0,0,0,1,4,3,9}, '{1,0,0,0,0,1,0,0,0,1,5,0,0}); // 30 load 15

        drive('{1,0,0,0,0,0,1,2,3,4});
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].i);
            @(negedge clk);
            check($sformatf("vec%0d", k), 32'(act), 32'(vecs[k].o));
            @(posedge clk); #1;
        end
        drive('{0,0,0,0,0,0,1,4,3,9});

        // SET_HR timeout, restarted by an inc after nine ticks
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 0, 0);
            @(negedge clk);
            check($sformatf("hr_tick%0d_mode", k), 32'(mode), 32'd1);
        end
        cyc(0, 0, 1);
        @(negedge clk);
        check("hr_restart_load", 32'({mode, hour_load, hour_d1, hour_d0}), 32'({2'd1, 1'b1, 2'd1, 4'd5}));
        cyc(0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 0);
            @(negedge clk);
            check($sformatf("hr_retick%0d_mode", k), 32'(mode), (k < 10) ? 32'd1 : 32'd0);
        end

        // SET_MIN timeout: back to RUN with a one-cycle sec_clr
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        @(negedge clk);
        check("min_entry_mode", 32'(mode), 32'd2);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 0);
            @(negedge clk);
            check($sformatf("min_tick%0d", k), 32'({mode, sec_clr}),
                  (k < 10) ? 32'({2'd2, 1'b0}) : 32'({2'd0, 1'b1}));
        end
        cyc(0, 0, 0);
        @(negedge clk);
        check("min_secclr_end", 32'({mode, sec_clr}), 32'({2'd0, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
